ex_mem_reg: RTL and testbench

- EX/MEM pipeline register directly downstream of the EX-stage ALU.
- Captures the ALU's 64-bit result and the EX-stage control fields into the MEM stage.
- Splits HI/LO write data and raises a stall request while the ALU's ok_o is low (multi-cycle divide).
- Implements hold, bubble and flush semantics under the pipeline-wide stall/flush controls.

---
 rtl/ex_mem_reg_pkg.sv | 38 +++
 rtl/ex_mem_reg_if.sv | 54 +++++
 rtl/ex_mem_reg_hilo_split.sv | 30 +++
 rtl/ex_mem_reg.sv | 100 ++++++++++
 tb/tb_ex_mem_reg.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline definitions for the EX/MEM register: stall bus layout,
// exception bit positions and the ALU operation / result-class codes.
package ex_mem_reg_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int EXCEPT_OV = 12;
    localparam int ALUOP_W   = 8;
    localparam int ALUSEL_W  = 3;

    typedef logic [STALL_W-1:0]  stall_bus_t;
    typedef logic [ALUOP_W-1:0]  aluop_t;
    typedef logic [ALUSEL_W-1:0] alusel_t;

    localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
    localparam aluop_t EXE_MTHI_OP  = 8'b0001_0001;
    localparam aluop_t EXE_MTLO_OP  = 8'b0001_0011;
    localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
    localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
    localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
    localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
    localparam aluop_t EXE_ADD_OP   = 8'b0010_0000;
    localparam aluop_t EXE_ADDU_OP  = 8'b0010_0001;
    localparam aluop_t EXE_OR_OP    = 8'b0010_0101;

    localparam alusel_t EXE_RES_NOP        = 3'b000;
    localparam alusel_t EXE_RES_LOGIC      = 3'b001;
    localparam alusel_t EXE_RES_MOVE       = 3'b011;
    localparam alusel_t EXE_RES_ARITHMETIC = 3'b100;

    // Multiply/divide results occupy the full 64-bit ALU output.
    function automatic logic is_muldiv(input aluop_t op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-to-MEM bundle: EX-stage result/control fields in, registered MEM fields
// and the stall request out. master = EX side, slave = the pipeline register.
interface ex_mem_reg_if
    import ex_mem_reg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
);
    logic              ex_valid_i;
    logic [ADDR_W-1:0] ex_pc_i;
    aluop_t            ex_aluop_i;
    alusel_t           ex_alusel_i;
    logic [REG_AW-1:0] ex_wd_i;
    logic              ex_wreg_i;
    logic [63:0]       ex_wdata_i;
    logic              ex_ok_i;
    logic              ex_overflow_i;
    logic [31:0]       ex_mem_addr_i;
    logic [31:0]       ex_reg2_i;
    logic              ex_in_delayslot_i;

    logic              stallreq_o;
    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_pc_o;
    aluop_t            mem_aluop_o;
    logic [REG_AW-1:0] mem_wd_o;
    logic              mem_wreg_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_whilo_o;
    logic [31:0]       mem_hi_o;
    logic [31:0]       mem_lo_o;
    logic [31:0]       mem_mem_addr_o;
    logic [31:0]       mem_reg2_o;
    logic [31:0]       mem_excepttype_o;
    logic              mem_in_delayslot_o;

    modport master (
        output ex_valid_i, ex_pc_i, ex_aluop_i, ex_alusel_i, ex_wd_i, ex_wreg_i,
               ex_wdata_i, ex_ok_i, ex_overflow_i, ex_mem_addr_i, ex_reg2_i,
               ex_in_delayslot_i,
        input  stallreq_o, mem_valid_o, mem_pc_o, mem_aluop_o, mem_wd_o, mem_wreg_o,
               mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o, mem_mem_addr_o,
               mem_reg2_o, mem_excepttype_o, mem_in_delayslot_o
    );

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_aluop_i, ex_alusel_i, ex_wd_i, ex_wreg_i,
               ex_wdata_i, ex_ok_i, ex_overflow_i, ex_mem_addr_i, ex_reg2_i,
               ex_in_delayslot_i,
        output stallreq_o, mem_valid_o, mem_pc_o, mem_aluop_o, mem_wd_o, mem_wreg_o,
               mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o, mem_mem_addr_o,
               mem_reg2_o, mem_excepttype_o, mem_in_delayslot_o
    );
endinterface

// File: rtl/ex_mem_reg_hilo_split.sv
// Maps the ALU operation and its 64-bit result onto HI/LO write data.
// MTHI/MTLO zero the other half; the MEM stage merges with architectural HI/LO.
module ex_mem_reg_hilo_split
    import ex_mem_reg_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [63:0] wdata,
    output logic        whilo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_comb begin
        whilo = 1'b0;
        hi    = '0;
        lo    = '0;
        if (is_muldiv(aluop)) begin
            whilo = 1'b1;
            hi    = wdata[63:32];
            lo    = wdata[31:0];
        end else if (aluop == EXE_MTHI_OP) begin
            whilo = 1'b1;
            hi    = wdata[31:0];
        end else if (aluop == EXE_MTLO_OP) begin
            whilo = 1'b1;
            lo    = wdata[31:0];
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result and control fields, with
// bubble/hold/flush sequencing and a stall request while the divider is busy.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  stall_bus_t stall_i,
    input  logic       flush_i,
    ex_mem_reg_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        aluop_t            aluop;
        logic [REG_AW-1:0] wd;
        logic              wreg;
        logic [31:0]       wdata;
        logic              whilo;
        logic [31:0]       hi;
        logic [31:0]       lo;
        logic [31:0]       mem_addr;
        logic [31:0]       reg2;
        logic [31:0]       excepttype;
        logic              in_delayslot;
    } mem_regs_t;

    mem_regs_t   q;
    mem_regs_t   captured;
    logic        split_whilo;
    logic [31:0] split_hi;
    logic [31:0] split_lo;
    logic        ov_hit;
    logic        bubble;
    logic        unused_stall;

    assign unused_stall = ^{stall_i[STALL_W-1], stall_i[STALL_EX-1:0]};

    ex_mem_reg_hilo_split u_hilo_split (
        .aluop (bus.ex_aluop_i),
        .wdata (bus.ex_wdata_i),
        .whilo (split_whilo),
        .hi    (split_hi),
        .lo    (split_lo)
    );

    // Overflow only matters for arithmetic-class results; it suppresses the
    // GPR write and is reported to MEM as an exception cause.
    assign ov_hit = bus.ex_overflow_i && (bus.ex_alusel_i == EXE_RES_ARITHMETIC);
    assign bubble = stall_i[STALL_EX] && !stall_i[STALL_MEM];

    always_comb begin
        captured = '0;
        if (bus.ex_valid_i) begin
            captured.valid                 = 1'b1;
            captured.pc                    = bus.ex_pc_i;
            captured.aluop                 = bus.ex_aluop_i;
            captured.wd                    = bus.ex_wd_i;
            captured.wreg                  = bus.ex_wreg_i && !ov_hit;
            captured.wdata                 = bus.ex_wdata_i[31:0];
            captured.whilo                 = split_whilo;
            captured.hi                    = split_hi;
            captured.lo                    = split_lo;
            captured.mem_addr              = bus.ex_mem_addr_i;
            captured.reg2                  = bus.ex_reg2_i;
            captured.excepttype[EXCEPT_OV] = ov_hit;
            captured.in_delayslot          = bus.ex_in_delayslot_i;
        end
    end

    // Reset, flush and an EX-stalled/MEM-running pipeline all load a bubble;
    // with both EX and MEM stalled the register simply holds.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || bubble) begin
            q <= '0;
        end else if (!stall_i[STALL_EX]) begin
            q <= captured;
        end
    end

    assign bus.stallreq_o         = !rst_i && bus.ex_valid_i && !bus.ex_ok_i;
    assign bus.mem_valid_o        = q.valid;
    assign bus.mem_pc_o           = q.pc;
    assign bus.mem_aluop_o        = q.aluop;
    assign bus.mem_wd_o           = q.wd;
    assign bus.mem_wreg_o         = q.wreg;
    assign bus.mem_wdata_o        = q.wdata;
    assign bus.mem_whilo_o        = q.whilo;
    assign bus.mem_hi_o           = q.hi;
    assign bus.mem_lo_o           = q.lo;
    assign bus.mem_mem_addr_o     = q.mem_addr;
    assign bus.mem_reg2_o         = q.reg2;
    assign bus.mem_excepttype_o   = q.excepttype;
    assign bus.mem_in_delayslot_o = q.in_delayslot;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: hand-computed expectations for capture,
// HI/LO split, divide stall, overflow, hold, flush and reset.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    stall_bus_t stall = '0;
    logic       flush = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;

    ex_mem_reg_if #(.ADDR_W(32), .REG_AW(5)) bus ();

    ex_mem_reg #(.ADDR_W(32), .REG_AW(5)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Drive the stall/flush controls for one edge, then sample 1 ns later.
    task automatic applyStimulus(input stall_bus_t s, input logic f);
        stall = s;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic setEx(input logic v, input aluop_t op, input alusel_t sel,
                         input logic [4:0] wd, input logic wreg, input logic [63:0] wdata,
                         input logic ok, input logic ov, input logic [31:0] pc);
        bus.ex_valid_i    = v;
        bus.ex_aluop_i    = op;
        bus.ex_alusel_i   = sel;
        bus.ex_wd_i       = wd;
        bus.ex_wreg_i     = wreg;
        bus.ex_wdata_i    = wdata;
        bus.ex_ok_i       = ok;
        bus.ex_overflow_i = ov;
        bus.ex_pc_i       = pc;
    endtask

    initial begin
        bus.ex_mem_addr_i     = 32'h0;
        bus.ex_reg2_i         = 32'h0;
        bus.ex_in_delayslot_i = 1'b0;
        setEx(1'b1, EXE_DIV_OP, EXE_RES_NOP, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);

        // Reset, with a busy divide presented: stall request must stay low.
        applyStimulus(6'b000000, 1'b0);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("reset_valid", {63'd0, bus.mem_valid_o}, 64'd0);
        checkOutput("reset_wdata", {32'd0, bus.mem_wdata_o}, 64'd0);
        checkOutput("reset_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("stallreq_after_reset", {63'd0, bus.stallreq_o}, 64'd1);

        // ADDU
        setEx(1'b1, EXE_ADDU_OP, EXE_RES_ARITHMETIC, 5'd8, 1'b1,
              64'h0000_0005_0000_0005, 1'b1, 1'b0, 32'h0000_0100);
        bus.ex_in_delayslot_i = 1'b1;
        applyStimulus(6'b000000, 1'b0);
        checkOutput("addu_wdata", {32'd0, bus.mem_wdata_o}, 64'd5);
        checkOutput("addu_wd", {59'd0, bus.mem_wd_o}, 64'd8);
        checkOutput("addu_wreg", {63'd0, bus.mem_wreg_o}, 64'd1);
        checkOutput("addu_whilo", {63'd0, bus.mem_whilo_o}, 64'd0);
        checkOutput("addu_valid_pc", {31'd0, bus.mem_valid_o, bus.mem_pc_o}, 64'h1_0000_0100);
        checkOutput("addu_delayslot", {63'd0, bus.mem_in_delayslot_o}, 64'd1);
        checkOutput("addu_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        bus.ex_in_delayslot_i = 1'b0;

        // MULT -2*3
        setEx(1'b1, EXE_MULT_OP, EXE_RES_NOP, 5'd0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0, 32'h0000_0104);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("mult_hilo", {bus.mem_hi_o, bus.mem_lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        checkOutput("mult_whilo", {63'd0, bus.mem_whilo_o}, 64'd1);
        checkOutput("mult_wreg", {63'd0, bus.mem_wreg_o}, 64'd0);
        checkOutput("mult_aluop", {56'd0, bus.mem_aluop_o}, 64'h18);

        // DIV 7/2 in flight for 33 cycles
        setEx(1'b1, EXE_DIV_OP, EXE_RES_NOP, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0000_0108);
        for (int i = 0; i < 33; i++) begin
            applyStimulus(6'b001111, 1'b0);
            checkOutput("div_stallreq", {63'd0, bus.stallreq_o}, 64'd1);
            checkOutput("div_bubble", {63'd0, bus.mem_valid_o}, 64'd0);
        end
        checkOutput("div_bubble_whilo", {63'd0, bus.mem_whilo_o}, 64'd0);
        bus.ex_ok_i    = 1'b1;
        bus.ex_wdata_i = 64'h0000_0001_0000_0003;
        #1;
        checkOutput("div_ok_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("div_hilo", {bus.mem_hi_o, bus.mem_lo_o}, 64'h0000_0001_0000_0003);
        checkOutput("div_valid_whilo", {62'd0, bus.mem_valid_o, bus.mem_whilo_o}, 64'd3);
        bus.ex_valid_i = 1'b0;
        applyStimulus(6'b000000, 1'b0);
        checkOutput("div_once", {62'd0, bus.mem_valid_o, bus.mem_whilo_o}, 64'd0);

        // ADD overflow 7FFF_FFFF + 1
        setEx(1'b1, EXE_ADD_OP, EXE_RES_ARITHMETIC, 5'd9, 1'b1,
              64'h0000_0000_8000_0000, 1'b1, 1'b1, 32'h0000_010C);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("ov_wreg", {63'd0, bus.mem_wreg_o}, 64'd0);
        checkOutput("ov_excepttype", {32'd0, bus.mem_excepttype_o}, 64'h0000_1000);
        checkOutput("ov_valid", {63'd0, bus.mem_valid_o}, 64'd1);

        // ORI captured, then held for 3 cycles while EX changes, then flushed
        setEx(1'b1, EXE_OR_OP, EXE_RES_LOGIC, 5'd3, 1'b1,
              64'hAAAA_AAAA_1234_5678, 1'b1, 1'b0, 32'h0000_0200);
        bus.ex_mem_addr_i = 32'h1000_0040;
        bus.ex_reg2_i     = 32'h5555_0000;
        applyStimulus(6'b000000, 1'b0);
        checkOutput("ori_excepttype", {32'd0, bus.mem_excepttype_o}, 64'd0);
        setEx(1'b1, EXE_ADDU_OP, EXE_RES_ARITHMETIC, 5'd7, 1'b0, 64'h99, 1'b1, 1'b0, 32'h0000_0300);
        bus.ex_mem_addr_i = 32'h0;
        bus.ex_reg2_i     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b011111, 1'b0);
            checkOutput("hold_wdata", {32'd0, bus.mem_wdata_o}, 64'h1234_5678);
            checkOutput("hold_wd_wreg", {58'd0, bus.mem_wd_o, bus.mem_wreg_o}, 64'h7);
            checkOutput("hold_pc_addr", {bus.mem_pc_o, bus.mem_mem_addr_o}, 64'h0000_0200_1000_0040);
            checkOutput("hold_reg2", {32'd0, bus.mem_reg2_o}, 64'h5555_0000);
        end
        applyStimulus(6'b011111, 1'b1);
        checkOutput("flush_valid", {63'd0, bus.mem_valid_o}, 64'd0);
        checkOutput("flush_wdata_pc", {bus.mem_pc_o, bus.mem_wdata_o}, 64'd0);
        checkOutput("flush_wreg", {63'd0, bus.mem_wreg_o}, 64'd0);

        // MTHI / MTLO
        setEx(1'b1, EXE_MTHI_OP, EXE_RES_NOP, 5'd0, 1'b0, 64'hDEAD_BEEF_CAFE_BABE, 1'b1, 1'b0, 32'h0);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("mthi_hilo", {bus.mem_hi_o, bus.mem_lo_o}, 64'hCAFE_BABE_0000_0000);
        checkOutput("mthi_whilo", {63'd0, bus.mem_whilo_o}, 64'd1);
        bus.ex_aluop_i = EXE_MTLO_OP;
        applyStimulus(6'b000000, 1'b0);
        checkOutput("mtlo_hilo", {bus.mem_hi_o, bus.mem_lo_o}, 64'h0000_0000_CAFE_BABE);

        // Invalid EX slot captures as a bubble
        setEx(1'b0, EXE_MULT_OP, EXE_RES_NOP, 5'd4, 1'b1, 64'h1234, 1'b1, 1'b0, 32'h400);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("invalid_bits", {61'd0, bus.mem_valid_o, bus.mem_wreg_o, bus.mem_whilo_o}, 64'd0);

        // Reset during a hold
        setEx(1'b1, EXE_OR_OP, EXE_RES_LOGIC, 5'd3, 1'b1, 64'h0000_00FF, 1'b1, 1'b0, 32'h500);
        applyStimulus(6'b000000, 1'b0);
        checkOutput("pre_reset_wdata", {32'd0, bus.mem_wdata_o}, 64'hFF);
        bus.ex_ok_i = 1'b0;
        rst = 1'b1;
        applyStimulus(6'b011111, 1'b0);
        checkOutput("rst_hold_wdata_pc", {bus.mem_pc_o, bus.mem_wdata_o}, 64'd0);
        checkOutput("rst_hold_valid_wreg", {62'd0, bus.mem_valid_o, bus.mem_wreg_o}, 64'd0);
        checkOutput("rst_hold_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
